// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO: mult after MUL_CYCLES edges, restoring divide in 34 edges.
// busy stays high while an operation is in flight; cancel aborts it without touching HI/LO.
module md_unit #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md,
    input  logic [1:0]  alu_md,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [5:0]  r_iter;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_div_zero;

    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    // alu_md[0]=0 selects the signed variant for both mult and div
    assign w_signed = ~alu_md[0];
    assign w_a_ext  = {{32{w_signed & src_a[31]}}, src_a};
    assign w_b_ext  = {{32{w_signed & src_b[31]}}, src_b};
    assign w_prod   = w_a_ext * w_b_ext;
    assign w_abs_a  = (w_signed & src_a[31]) ? -src_a : src_a;
    assign w_abs_b  = (w_signed & src_b[31]) ? -src_b : src_b;

    // Remainder stays below the divisor, so a 33-bit trial subtract's MSB is the borrow
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_sub    = w_shift - {1'b0, r_dvs};
    assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_iter     <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else if (md) begin
                        if (!alu_md[1]) begin
                            r_state <= S_MUL;
                            r_cnt   <= MUL_INIT;
                            r_prod  <= w_prod;
                        end else begin
                            r_state <= S_DIV;
                            r_iter  <= '0;
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_neg_q <= w_signed & (src_a[31] ^ src_b[31]);
                            r_neg_r <= w_signed & src_a[31];
                            r_dz    <= (src_b == 32'd0);
                        end
                    end else begin
                        if (op_mthi) r_hi <= src_a;
                        if (op_mtlo) r_lo <= src_a;
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_hi    <= r_prod[63:32];
                        r_lo    <= r_prod[31:0];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else if (r_iter == 6'd32) begin
                        r_state <= S_FIX;
                    end else begin
                        r_iter <= r_iter + 6'd1;
                        if (!w_sub[32]) begin
                            r_rem <= w_sub[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[31:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        // Zero divisor: remainder already equals the dividend; quotient forced to all ones
                        r_hi       <= w_r_fix;
                        r_lo       <= r_dz ? 32'hFFFF_FFFF : w_q_fix;
                        r_done     <= 1'b1;
                        r_div_zero <= r_dz;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of mult/div vectors plus hand-built cancel, mt*, and reset sequences.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        md;
    logic [1:0]  alu_md;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        op_mthi;
    logic        op_mtlo;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    md_unit #(.MUL_CYCLES(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .md       (md),
        .alu_md   (alu_md),
        .src_a    (src_a),
        .src_b    (src_b),
        .op_mthi  (op_mthi),
        .op_mtlo  (op_mtlo),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one operation at the next negedge and follows it to the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input string tag);
        int cyc;
        int ecyc;
        ecyc = op[1] ? 34 : 3;
        @(negedge clk);
        md = 1'b1; alu_md = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        md = 1'b0; src_a = 32'h0; src_b = 32'h0;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, " done_low_after_accept"}, 64'(done), 64'd0);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        check({tag, " busy_cycles"}, 64'(cyc), 64'(ecyc));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        logic [31:0] save_hi;
        logic [31:0] save_lo;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[5]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

        rst_n = 1'b0; md = 1'b0; alu_md = 2'b00; src_a = '0; src_b = '0;
        op_mthi = 1'b0; op_mtlo = 1'b0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: each vector is issued in the done cycle of the previous one
        for (int i = 0; i < 11; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].edz,
                   $sformatf("vec%0d", i));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);

        @(negedge clk);
        op_mthi = 1'b1; src_a = 32'hAAAA5555;
        @(posedge clk); #1;
        op_mthi = 1'b0;
        check("mthi hi", 64'(hi), 64'hAAAA5555);
        check("mthi no_done", 64'(done), 64'd0);
        @(negedge clk);
        op_mthi = 1'b1; op_mtlo = 1'b1; src_a = 32'h13572468;
        @(posedge clk); #1;
        op_mthi = 1'b0; op_mtlo = 1'b0;
        check("mthilo hi", 64'(hi), 64'h13572468);
        check("mthilo lo", 64'(lo), 64'h13572468);

        @(negedge clk);
        cancel = 1'b1; md = 1'b1; alu_md = 2'b00; src_a = 32'd4; src_b = 32'd4;
        @(posedge clk); #1;
        cancel = 1'b0; md = 1'b0;
        check("cancel_idle busy", 64'(busy), 64'd0);

        // Cancel a divide ten cycles in
        @(negedge clk);
        md = 1'b1; alu_md = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        md = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_div busy", 64'(busy), 64'd0);
        check("cancel_div hi", 64'(hi), 64'h13572468);
        check("cancel_div lo", 64'(lo), 64'h13572468);
        check("cancel_div done", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("cancel_div done_later", 64'(done), 64'd0);

        // Cancel landing on the multiply write edge
        @(negedge clk);
        md = 1'b1; alu_md = 2'b01; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        md = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_mul busy", 64'(busy), 64'd0);
        check("cancel_mul lo", 64'(lo), 64'h13572468);
        check("cancel_mul done", 64'(done), 64'd0);

        // mtlo while busy must be ignored
        fork
            run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "mul_mtlo");
            begin
                @(negedge clk); @(negedge clk);
                op_mtlo = 1'b1; src_a = 32'hDEADBEEF;
                @(negedge clk);
                op_mtlo = 1'b0; src_a = 32'h0;
            end
        join

        // Async reset in the middle of a divide
        @(negedge clk);
        md = 1'b1; alu_md = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        md = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        save_hi = hi; save_lo = lo;
        rst_n = 1'b0;
        #1;
        check("arst busy", 64'(busy), 64'd0);
        check("arst hi", 64'(hi), 64'd0);
        check("arst lo", 64'(lo), 64'd0);
        check("arst lo_was_nonzero", 64'(save_lo != 32'd0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "post_reset_mul");
        @(posedge clk); #1;
        check("post_reset done_one_cycle", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide execution unit with architectural HI/LO registers; sits in EX, downstream of the control unit.
- Consumes the decoded md, alu_md, op_mthi, op_mtlo plus EX-stage operands.
- Multiply uses a counted latency; divide uses 32-iteration restoring division.
- Raises busy so the hazard unit stalls the pipeline; provides hi/lo for the mfhi/mflo datapath.

Parameters:
MUL_CYCLES, 3, cycles from accepted mult/multu to HI/LO update (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
md  input  1  EX-stage mult/multu/div/divu request (start)
alu_md  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with md
src_a  input  32  rs operand (multiplicand / dividend)
src_b  input  32  rt operand (multiplier / divisor)
op_mthi  input  1  write src_a to HI
op_mtlo  input  1  write src_a to LO
cancel  input  1  exception/flush: abort any in-flight operation
busy  output  1  operation in flight (state != IDLE)
done  output  1  one-cycle pulse, cycle after HI/LO updated by an operation
div_zero  output  1  one-cycle pulse with done when divisor was 0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0; aborts any operation mid-flight, no partial result written.
- States: IDLE, MUL, DIV, FIX.
- IDLE priority, highest first: cancel, md, op_mthi/op_mtlo. With cancel=1 nothing is accepted.
- md=1 in IDLE: latch alu_md and operands.
  - mult/multu: go to MUL, counter=MUL_CYCLES-1; register full 64-bit product (signed for 00, unsigned for 01).
  - div/divu: go to DIV, store |a|, |b| (signed) or raw values (unsigned), record quotient/remainder signs, iteration count=0.
- md ignored outside IDLE; the hazard unit holds the instruction while busy=1.
- op_mthi/op_mtlo in IDLE (md=0): hi<=src_a / lo<=src_a next edge. Both asserted: both written. Ignored when busy. No done pulse.
- MUL: counter decrements each cycle. At counter=0: hi<=product[63:32], lo<=product[31:0], go IDLE.
  - Accept edge to write edge = MUL_CYCLES edges; busy high MUL_CYCLES cycles.
- DIV: one restoring step per cycle (shift remainder/quotient, trial subtract 33-bit, keep if non-negative). After 32 steps go FIX.
- FIX: apply signs. Quotient negated if dividend and divisor signs differ; remainder takes dividend sign. hi<=remainder, lo<=quotient, go IDLE.
  - Div total: 34 edges from accept to HI/LO write; busy high 34 cycles.
- Divide by zero (src_b=0): full 34-cycle duration. lo=FFFFFFFF, hi=src_a (unsigned and signed alike). div_zero pulses with done.
- Signed 0x80000000 / 0xFFFFFFFF: lo=80000000, hi=00000000; no flag.
- done/div_zero: registered, asserted the cycle after the HI/LO write edge, exactly one cycle.
- cancel=1 in MUL/DIV/FIX: next edge returns to IDLE. hi/lo keep pre-operation values; no done.
  - cancel on the same edge FIX/MUL would write: cancel wins, no write.
- hi/lo outputs come straight from registers; no bypass of in-flight results.
- Back-to-back: md may be accepted in the IDLE cycle immediately after a write; the done pulse of the previous op still fires.

Test Plan:
- mult src_a=FFFFFFFD (-3), src_b=00000005 -> busy 3 cycles; after edge 3 hi=FFFFFFFF, lo=FFFFFFF1; done pulse 1 cycle later.
- multu FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; then mult same operands -> hi=00000000, lo=00000001.
- div FFFFFFF9 (-7) / 00000002 -> busy 34 cycles; lo=FFFFFFFD, hi=FFFFFFFF. divu 00000007/00000002 -> lo=3, hi=1.
- divu 12345678 / 0 -> lo=FFFFFFFF, hi=12345678, div_zero and done both high one cycle. div 80000000/FFFFFFFF -> lo=80000000, hi=0.
- op_mthi src_a=AAAA5555 in IDLE -> hi=AAAA5555 next edge. Start div, cancel at cycle 10 -> busy drops next cycle, hi/lo unchanged, no done. Start mult with op_mtlo asserted while busy -> mtlo ignored.
- Start div, deassert rst_n at cycle 20 -> hi=lo=0, busy=0 immediately (async). Release reset, issue mult 2x3 -> lo=6, hi=0.
